intersection_ctrl: RTL and testbench

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_intersection_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/intersection_ctrl.sv
// Traffic intersection sequencer: NS/EW phase rotation with pedestrian walk
// phase, emergency hold, and programmable per-phase durations.
//
// state | meaning
// NS_G  | north-south green
// NS_Y  | north-south yellow
// AR_NS | all-red after north-south
// EW_G  | east-west green
// EW_Y  | east-west yellow
// AR_EW | all-red after east-west (reset state)
// WALK  | pedestrian walk, all vehicle lamps red
// EMG   | emergency hold, untimed
module intersection_ctrl #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_addr,
   input  logic [CW-1:0] cfg_data,
   input  logic          ped_req,
   input  logic          emg_req,
   output logic [2:0]    ns_light,
   output logic [2:0]    ew_light,
   output logic          walk,
   output logic          ped_ack,
   output logic          emg_active
);

   typedef enum logic [2:0] {NS_G, NS_Y, AR_NS, EW_G, EW_Y, AR_EW, WALK, EMG} state_t;

   localparam logic [2:0]    LAMP_R = 3'b001;
   localparam logic [2:0]    LAMP_G = 3'b010;
   localparam logic [2:0]    LAMP_Y = 3'b100;
   localparam logic [CW-1:0] ONE    = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ped_pend_q, ped_pend_d;
   logic          ped_ack_q, ped_ack_d;
   logic          walk_to_ew_q, walk_to_ew_d;
   logic [CW-1:0] green_q, green_d;
   logic [CW-1:0] yellow_q, yellow_d;
   logic [CW-1:0] allred_q, allred_d;
   logic [CW-1:0] walk_dur_q, walk_dur_d;
   logic          expired;
   logic          enter_walk;

   // A zero duration behaves as one cycle.
   function automatic logic [CW-1:0] load_val(input logic [CW-1:0] d);
      return (d == '0) ? '0 : d - ONE;
   endfunction

   always_comb begin
      green_d    = green_q;
      yellow_d   = yellow_q;
      allred_d   = allred_q;
      walk_dur_d = walk_dur_q;
      if (cfg_we) begin
         case (cfg_addr)
            2'd0:    green_d    = cfg_data;
            2'd1:    yellow_d   = cfg_data;
            2'd2:    allred_d   = cfg_data;
            default: walk_dur_d = cfg_data;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      expired      = (cnt_q == '0);
      cnt_d        = expired ? '0 : cnt_q - ONE;
      ped_ack_d    = 1'b0;
      walk_to_ew_d = walk_to_ew_q;
      enter_walk   = 1'b0;
      case (state_q)
         NS_G: if (emg_req || expired) begin
            state_d = NS_Y;
            cnt_d   = load_val(yellow_q);
         end
         NS_Y: if (expired) begin
            state_d = AR_NS;
            cnt_d   = load_val(allred_q);
         end
         AR_NS: if (expired) begin
            if (emg_req) begin
               state_d = EMG;
               cnt_d   = '0;
            end else if (ped_pend_q) begin
               state_d      = WALK;
               cnt_d        = load_val(walk_dur_q);
               enter_walk   = 1'b1;
               walk_to_ew_d = 1'b1;
            end else begin
               state_d = EW_G;
               cnt_d   = load_val(green_q);
            end
         end
         EW_G: if (emg_req || expired) begin
            state_d = EW_Y;
            cnt_d   = load_val(yellow_q);
         end
         EW_Y: if (expired) begin
            state_d = AR_EW;
            cnt_d   = load_val(allred_q);
         end
         AR_EW: if (expired) begin
            if (emg_req) begin
               state_d = EMG;
               cnt_d   = '0;
            end else if (ped_pend_q) begin
               state_d      = WALK;
               cnt_d        = load_val(walk_dur_q);
               enter_walk   = 1'b1;
               walk_to_ew_d = 1'b0;
            end else begin
               state_d = NS_G;
               cnt_d   = load_val(green_q);
            end
         end
         WALK: if (emg_req) begin
            state_d = EMG;
            cnt_d   = '0;
         end else if (expired) begin
            state_d = walk_to_ew_q ? EW_G : NS_G;
            cnt_d   = load_val(green_q);
         end
         EMG: begin
            cnt_d = '0;
            if (!emg_req) begin
               state_d = AR_EW;
               cnt_d   = load_val(allred_q);
            end
         end
         default: begin
            state_d = AR_EW;
            cnt_d   = load_val(allred_q);
         end
      endcase
      ped_ack_d = enter_walk;
   end

   // Serving the request on walk entry wins over a same-cycle new request.
   always_comb begin
      ped_pend_d = ped_pend_q;
      if (enter_walk)
         ped_pend_d = 1'b0;
      else if (ped_req && state_q != WALK)
         ped_pend_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= AR_EW;
         cnt_q        <= CW'(1);
         ped_pend_q   <= 1'b0;
         ped_ack_q    <= 1'b0;
         walk_to_ew_q <= 1'b0;
         green_q      <= CW'(8);
         yellow_q     <= CW'(3);
         allred_q     <= CW'(2);
         walk_dur_q   <= CW'(6);
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ped_pend_q   <= ped_pend_d;
         ped_ack_q    <= ped_ack_d;
         walk_to_ew_q <= walk_to_ew_d;
         green_q      <= green_d;
         yellow_q     <= yellow_d;
         allred_q     <= allred_d;
         walk_dur_q   <= walk_dur_d;
      end
   end

   always_comb begin
      ns_light   = LAMP_R;
      ew_light   = LAMP_R;
      walk       = (state_q == WALK);
      emg_active = (state_q == EMG);
      ped_ack    = ped_ack_q;
      case (state_q)
         NS_G:    ns_light = LAMP_G;
         NS_Y:    ns_light = LAMP_Y;
         EW_G:    ew_light = LAMP_G;
         EW_Y:    ew_light = LAMP_Y;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl: phase-segment table plus hand-written
// reset and configuration sequences, checked every cycle.
module tb_intersection_ctrl;

   localparam int CW = 8;
   localparam logic [2:0] R = 3'b001;
   localparam logic [2:0] G = 3'b010;
   localparam logic [2:0] Y = 3'b100;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [1:0]    cfg_addr;
   logic [CW-1:0] cfg_data;
   logic          ped_req;
   logic          emg_req;
   logic [2:0]    ns_light;
   logic [2:0]    ew_light;
   logic          walk;
   logic          ped_ack;
   logic          emg_active;

   int checks = 0;
   int errors = 0;

   intersection_ctrl #(.CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .ped_req    (ped_req),
      .emg_req    (emg_req),
      .ns_light   (ns_light),
      .ew_light   (ew_light),
      .walk       (walk),
      .ped_ack    (ped_ack),
      .emg_active (emg_active)
   );

   always #5 clk = ~clk;

   // n cycles with constant inputs and constant expected outputs
   typedef struct {
      int         n;
      logic       ped;
      logic       emg;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       wk;
      logic       ack;
      logic       ea;
   } seg_t;

   seg_t tbl[$];

   function automatic seg_t mk(int n, logic p, logic e, logic [2:0] ns, logic [2:0] ew,
                               logic wk, logic ack, logic ea);
      seg_t s;
      s.n = n; s.ped = p; s.emg = e; s.ns = ns; s.ew = ew;
      s.wk = wk; s.ack = ack; s.ea = ea;
      return s;
   endfunction

   task automatic check_out(input string tag, input int cyc, input logic [2:0] ns,
                            input logic [2:0] ew, input logic wk, input logic ack,
                            input logic ea);
      checks++;
      if ({ns_light, ew_light, walk, ped_ack, emg_active} !== {ns, ew, wk, ack, ea}) begin
         errors++;
         $display("FAIL %s cyc %0d got ns=%b ew=%b walk=%b ack=%b emg=%b want ns=%b ew=%b walk=%b ack=%b emg=%b",
                  tag, cyc, ns_light, ew_light, walk, ped_ack, emg_active, ns, ew, wk, ack, ea);
      end
   endtask

   task automatic run_seg(input string tag, input seg_t s);
      for (int i = 0; i < s.n; i++) begin
         ped_req = s.ped;
         emg_req = s.emg;
         check_out(tag, i, s.ns, s.ew, s.wk, s.ack, s.ea);
         @(posedge clk);
         #1;
      end
      ped_req = 1'b0;
      emg_req = 1'b0;
   endtask

   task automatic run_cfg(input string tag, input logic [1:0] a, input logic [CW-1:0] d,
                          input logic [2:0] ns, input logic [2:0] ew);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      run_seg(tag, mk(1, 0, 0, ns, ew, 0, 0, 0));
      cfg_we   = 1'b0;
   endtask

   // Entered one time unit after a rising edge; leaves rst released mid-cycle.
   task automatic do_reset(input string tag);
      #3 rst = 1'b1;
      #1 check_out(tag, 0, R, R, 0, 0, 0);
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   task automatic run_period(input string tag);
      run_seg(tag, mk(2, 0, 0, R, R, 0, 0, 0));
      run_seg(tag, mk(8, 0, 0, G, R, 0, 0, 0));
      run_seg(tag, mk(3, 0, 0, Y, R, 0, 0, 0));
      run_seg(tag, mk(2, 0, 0, R, R, 0, 0, 0));
      run_seg(tag, mk(8, 0, 0, R, G, 0, 0, 0));
      run_seg(tag, mk(3, 0, 0, R, Y, 0, 0, 0));
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      ped_req = 1'b0; emg_req = 1'b0;

      // free-running rotation, two periods
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      tbl.push_back(mk(8, 0, 0, G, R, 0, 0, 0));
      tbl.push_back(mk(3, 0, 0, Y, R, 0, 0, 0));
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      tbl.push_back(mk(8, 0, 0, R, G, 0, 0, 0));
      tbl.push_back(mk(3, 0, 0, R, Y, 0, 0, 0));
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      // ped pulse in NS_G, walk after AR_NS, requests in WALK ignored
      tbl.push_back(mk(1, 1, 0, G, R, 0, 0, 0));
      tbl.push_back(mk(7, 0, 0, G, R, 0, 0, 0));
      tbl.push_back(mk(3, 0, 0, Y, R, 0, 0, 0));
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, R, R, 1, 1, 0));
      tbl.push_back(mk(5, 1, 0, R, R, 1, 0, 0));
      tbl.push_back(mk(8, 0, 0, R, G, 0, 0, 0));
      tbl.push_back(mk(3, 0, 0, R, Y, 0, 0, 0));
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      tbl.push_back(mk(8, 0, 0, G, R, 0, 0, 0));
      tbl.push_back(mk(3, 0, 0, Y, R, 0, 0, 0));
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      // emergency raised in 2nd EW_G cycle, held 10 cycles
      tbl.push_back(mk(1, 0, 0, R, G, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, R, G, 0, 0, 0));
      tbl.push_back(mk(3, 0, 1, R, Y, 0, 0, 0));
      tbl.push_back(mk(2, 0, 1, R, R, 0, 0, 0));
      tbl.push_back(mk(4, 0, 1, R, R, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, R, R, 0, 0, 1));
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      // ped and emergency both pending at AR_NS expiry
      tbl.push_back(mk(1, 1, 0, G, R, 0, 0, 0));
      tbl.push_back(mk(7, 0, 0, G, R, 0, 0, 0));
      tbl.push_back(mk(3, 0, 0, Y, R, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, R, R, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, R, R, 0, 0, 0));
      tbl.push_back(mk(3, 0, 1, R, R, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, R, R, 0, 0, 1));
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, R, R, 1, 1, 0));
      tbl.push_back(mk(5, 0, 0, R, R, 1, 0, 0));
      // emergency during WALK
      tbl.push_back(mk(1, 1, 0, G, R, 0, 0, 0));
      tbl.push_back(mk(7, 0, 0, G, R, 0, 0, 0));
      tbl.push_back(mk(3, 0, 0, Y, R, 0, 0, 0));
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, R, R, 1, 1, 0));
      tbl.push_back(mk(1, 0, 0, R, R, 1, 0, 0));
      tbl.push_back(mk(1, 0, 1, R, R, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, R, R, 0, 0, 1));
      tbl.push_back(mk(2, 0, 0, R, R, 0, 0, 0));
      tbl.push_back(mk(8, 0, 0, G, R, 0, 0, 0));

      #2 check_out("por", 0, R, R, 0, 0, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      foreach (tbl[k]) run_seg($sformatf("tbl%0d", k), tbl[k]);

      // reset in the middle of WALK
      do_reset("rst_a");
      run_seg("walk_pre", mk(2, 0, 0, R, R, 0, 0, 0));
      run_seg("walk_pre", mk(1, 1, 0, G, R, 0, 0, 0));
      run_seg("walk_pre", mk(7, 0, 0, G, R, 0, 0, 0));
      run_seg("walk_pre", mk(3, 0, 0, Y, R, 0, 0, 0));
      run_seg("walk_pre", mk(2, 0, 0, R, R, 0, 0, 0));
      run_seg("walk_pre", mk(1, 0, 0, R, R, 1, 1, 0));
      run_seg("walk_pre", mk(1, 0, 0, R, R, 1, 0, 0));
      do_reset("rst_walk");
      run_period("post_walk");

      // reset discards a latched pedestrian request
      do_reset("rst_b");
      run_seg("pend_pre", mk(2, 0, 0, R, R, 0, 0, 0));
      run_seg("pend_pre", mk(1, 1, 0, G, R, 0, 0, 0));
      run_seg("pend_pre", mk(2, 0, 0, G, R, 0, 0, 0));
      do_reset("rst_pend");
      run_period("post_pend");
      run_seg("post_pend", mk(2, 0, 0, R, R, 0, 0, 0));
      run_seg("post_pend", mk(1, 0, 0, G, R, 0, 0, 0));

      // duration writes take effect at the next entry only
      do_reset("rst_c");
      run_seg("cfg", mk(2, 0, 0, R, R, 0, 0, 0));
      run_cfg("cfg_g0", 2'd0, 8'd0, G, R);
      run_seg("cfg_ns_g", mk(7, 0, 0, G, R, 0, 0, 0));
      run_seg("cfg", mk(3, 0, 0, Y, R, 0, 0, 0));
      run_cfg("cfg_y5", 2'd1, 8'd5, R, R);
      run_seg("cfg", mk(1, 0, 0, R, R, 0, 0, 0));
      run_seg("cfg_ew_g1", mk(1, 0, 0, R, G, 0, 0, 0));
      run_seg("cfg_ew_y5", mk(5, 0, 0, R, Y, 0, 0, 0));
      run_seg("cfg", mk(1, 0, 0, R, R, 0, 0, 0));
      run_cfg("cfg_g4_edge", 2'd0, 8'd4, R, R);
      run_seg("cfg_old_g", mk(1, 0, 0, G, R, 0, 0, 0));
      run_seg("cfg_ns_y5", mk(5, 0, 0, Y, R, 0, 0, 0));
      run_seg("cfg", mk(2, 0, 0, R, R, 0, 0, 0));
      run_seg("cfg_ew_g4", mk(4, 0, 0, R, G, 0, 0, 0));
      run_seg("cfg_ew_y5b", mk(5, 0, 0, R, Y, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
